data_mem_controller: RTL and testbench

- Sequences every load/store in the MEM stage of the 5-stage RISC-V pipeline against a variable-latency data-memory bus with a valid/ready request and a response channel.
- Freezes the upstream pipeline while an access is outstanding.
- Produces aligned, sign/zero-extended RdataM for the MEM/WB pipeline register, which captures it on the cycle the stall releases.
- Flags misaligned accesses and bus errors/timeouts instead of issuing or completing them.

---
 rtl/data_mem_pkg.sv | 34 +++
 rtl/data_mem_controller_lsu_load_align.sv | 36 +++
 rtl/data_mem_controller.sv | 123 ++++++++++++
 tb/tb_data_mem_controller.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_pkg.sv
// Shared types and store-side helpers for the MEM-stage data memory controller.
package data_mem_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        DONE,
        ERR
    } state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    function automatic logic [3:0] be_of(input logic [2:0] f3, input logic [1:0] off);
        case (f3[1:0])
            2'b00:   return 4'b0001 << off;
            2'b01:   return 4'b0011 << off;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_lanes(input logic [2:0] f3, input logic [31:0] wd);
        case (f3[1:0])
            2'b00:   return {4{wd[7:0]}};
            2'b01:   return {2{wd[15:0]}};
            default: return wd;
        endcase
    endfunction

endpackage

// File: rtl/data_mem_controller_lsu_load_align.sv
// Load lane selection with sign/zero extension, plus access-size misalignment detection.
module lsu_load_align
    import data_mem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  off,
    input  logic [2:0]  funct3,
    output logic [31:0] data,
    output logic        misalign
);

    logic [7:0]  b;
    logic [15:0] h;

    always_comb begin
        b = word[{off, 3'b000} +: 8];
        h = off[1] ? word[31:16] : word[15:0];

        data = word;
        case (funct3)
            F3_B:    data = {{24{b[7]}}, b};
            F3_BU:   data = {24'h0, b};
            F3_H:    data = {{16{h[15]}}, h};
            F3_HU:   data = {16'h0, h};
            default: data = word;
        endcase

        misalign = 1'b0;
        case (funct3[1:0])
            2'b01:   misalign = off[0];
            2'b10:   misalign = (off != 2'b00);
            default: misalign = 1'b0;
        endcase
    end

endmodule

// File: rtl/data_mem_controller.sv
// MEM-stage load/store sequencer: issues one bus request per access, stalls the
// pipeline until the response (or error/timeout), then presents extended load data.
module data_mem_controller
    import data_mem_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned CNT_W          = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        MemReadM,
    input  logic        MemWriteM,
    input  logic [2:0]  Funct3M,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    output logic        StallMem,
    output logic [31:0] RdataM,
    output logic        MisalignM,
    output logic        BusErrM,
    output logic        req_valid,
    input  logic        req_ready,
    output logic        req_we,
    output logic [31:0] req_addr,
    output logic [31:0] req_wdata,
    output logic [3:0]  req_be,
    input  logic        rsp_valid,
    input  logic [31:0] rsp_rdata,
    input  logic        rsp_err
);

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      hold;
    logic [31:0]      ext;
    logic             access;
    logic             misalign;
    logic             timeout;

    // Gating with rst_n keeps every output low while reset is held, even with an access present.
    assign access  = rst_n & (MemReadM | MemWriteM);
    assign timeout = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    lsu_load_align u_align (
        .word     (hold),
        .off      (ALUResultM[1:0]),
        .funct3   (Funct3M),
        .data     (ext),
        .misalign (misalign)
    );

    always_comb begin
        state_nx  = state;
        StallMem  = 1'b0;
        MisalignM = 1'b0;
        BusErrM   = 1'b0;
        RdataM    = '0;
        req_valid = 1'b0;
        case (state)
            IDLE: begin
                if (access) begin
                    if (misalign) begin
                        MisalignM = 1'b1;
                    end else begin
                        StallMem = 1'b1;
                        state_nx = REQ;
                    end
                end
            end
            REQ: begin
                req_valid = 1'b1;
                StallMem  = 1'b1;
                if (req_ready)    state_nx = WAIT;
                else if (timeout) state_nx = ERR;
            end
            WAIT: begin
                StallMem = 1'b1;
                if (rsp_valid)    state_nx = rsp_err ? ERR : DONE;
                else if (timeout) state_nx = ERR;
            end
            DONE: begin
                if (!req_we) RdataM = ext;
                state_nx = IDLE;
            end
            ERR: begin
                BusErrM  = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            req_we    <= 1'b0;
            req_addr  <= '0;
            req_wdata <= '0;
            req_be    <= '0;
            hold      <= '0;
            cnt       <= '0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: begin
                    if (access && !misalign) begin
                        req_we    <= MemWriteM;
                        req_addr  <= {ALUResultM[31:2], 2'b00};
                        req_be    <= be_of(Funct3M, ALUResultM[1:0]);
                        req_wdata <= store_lanes(Funct3M, WriteDataM);
                        cnt       <= '0;
                    end
                end
                REQ: cnt <= cnt + CNT_W'(1);
                WAIT: begin
                    cnt <= cnt + CNT_W'(1);
                    if (rsp_valid && !rsp_err) hold <= rsp_rdata;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_controller.sv
// Directed bench for data_mem_controller with hand-computed expectations.
module tb_data_mem_controller;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        MemReadM, MemWriteM;
    logic [2:0]  Funct3M;
    logic [31:0] ALUResultM, WriteDataM;
    logic        StallMem, MisalignM, BusErrM;
    logic [31:0] RdataM;
    logic        req_valid, req_ready, req_we;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_be;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    data_mem_controller #(.TIMEOUT_CYCLES(8), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .MemReadM(MemReadM), .MemWriteM(MemWriteM), .Funct3M(Funct3M),
        .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
        .StallMem(StallMem), .RdataM(RdataM), .MisalignM(MisalignM), .BusErrM(BusErrM),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        MemReadM  = 1'b0;
        MemWriteM = 1'b0;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        rsp_err   = 1'b0;
    endtask

    // Load with ready on the first REQ cycle and the response on the first WAIT cycle.
    task automatic do_load(input string tag, input logic [31:0] addr, input logic [2:0] f3,
                           input logic [31:0] rdata, input logic [31:0] exp_addr,
                           input logic [3:0] exp_be, input logic [31:0] exp_rd);
        MemReadM = 1'b1; MemWriteM = 1'b0; Funct3M = f3; ALUResultM = addr; req_ready = 1'b1;
        #1;
        chk({tag, "_idle_stall"}, StallMem, 1);
        chk({tag, "_idle_valid"}, req_valid, 0);
        tick();
        chk({tag, "_req_valid"}, req_valid, 1);
        chk({tag, "_req_stall"}, StallMem, 1);
        chk({tag, "_req_addr"}, req_addr, exp_addr);
        chk({tag, "_req_be"}, req_be, exp_be);
        chk({tag, "_req_we"}, req_we, 0);
        tick();
        chk({tag, "_wait_valid"}, req_valid, 0);
        chk({tag, "_wait_stall"}, StallMem, 1);
        rsp_valid = 1'b1; rsp_rdata = rdata;
        tick();
        rsp_valid = 1'b0; rsp_rdata = 32'h0;
        #1;
        chk({tag, "_done_stall"}, StallMem, 0);
        chk({tag, "_done_rdata"}, RdataM, exp_rd);
        chk({tag, "_done_valid"}, req_valid, 0);
        tick();
        idle_inputs();
        #1;
        chk({tag, "_post_stall"}, StallMem, 0);
        chk({tag, "_post_rdata"}, RdataM, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        Funct3M = 3'b000; ALUResultM = 32'h0; WriteDataM = 32'h0; rsp_rdata = 32'h0;
        #3;
        chk("rst_stall", StallMem, 0);
        chk("rst_valid", req_valid, 0);
        chk("rst_addr", req_addr, 0);
        chk("rst_be", req_be, 0);
        chk("rst_wdata", req_wdata, 0);
        chk("rst_we", req_we, 0);
        chk("rst_rdata", RdataM, 0);
        chk("rst_buserr", BusErrM, 0);
        chk("rst_misalign", MisalignM, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();

        do_load("lw100", 32'h100, 3'b010, 32'hDEADBEEF, 32'h100, 4'b1111, 32'hDEADBEEF);
        do_load("lb203", 32'h203, 3'b000, 32'h80112233, 32'h200, 4'b1000, 32'hFFFFFF80);
        do_load("lbu203", 32'h203, 3'b100, 32'h80112233, 32'h200, 4'b1000, 32'h00000080);
        do_load("lh302", 32'h302, 3'b001, 32'h9ABC1234, 32'h300, 4'b1100, 32'hFFFF9ABC);
        do_load("lhu300", 32'h300, 3'b101, 32'h9ABC8234, 32'h300, 4'b0011, 32'h00008234);

        // SH 0x302 held off by ready=0 for five REQ cycles
        MemWriteM = 1'b1; Funct3M = 3'b001; ALUResultM = 32'h302; WriteDataM = 32'h0000ABCD;
        req_ready = 1'b0;
        #1;
        chk("sh_idle_stall", StallMem, 1);
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("sh_hold_valid", req_valid, 1);
            chk("sh_hold_we", req_we, 1);
            chk("sh_hold_addr", req_addr, 32'h300);
            chk("sh_hold_be", req_be, 4'b1100);
            chk("sh_hold_wdata", req_wdata, 32'hABCDABCD);
            chk("sh_hold_stall", StallMem, 1);
            tick();
        end
        req_ready = 1'b1;
        #1;
        chk("sh_acc_valid", req_valid, 1);
        chk("sh_acc_wdata", req_wdata, 32'hABCDABCD);
        tick();
        req_ready = 1'b0;
        chk("sh_wait_valid", req_valid, 0);
        rsp_valid = 1'b1; rsp_rdata = 32'h55555555;
        tick();
        rsp_valid = 1'b0;
        #1;
        chk("sh_done_stall", StallMem, 0);
        chk("sh_done_rdata", RdataM, 0);
        tick();
        idle_inputs();
        #1;

        // SB 0x001: lane 1 byte enable, byte replicated
        MemWriteM = 1'b1; Funct3M = 3'b000; ALUResultM = 32'h001; WriteDataM = 32'h123456A5;
        req_ready = 1'b1;
        tick();
        chk("sb_be", req_be, 4'b0010);
        chk("sb_wdata", req_wdata, 32'hA5A5A5A5);
        chk("sb_addr", req_addr, 32'h0);
        tick();
        rsp_valid = 1'b1;
        tick();
        rsp_valid = 1'b0;
        tick();
        idle_inputs();
        #1;

        // misaligned LW / LH: flagged in IDLE, never requested
        MemReadM = 1'b1; Funct3M = 3'b010; ALUResultM = 32'h101; req_ready = 1'b1;
        #1;
        chk("mis_lw_flag", MisalignM, 1);
        chk("mis_lw_stall", StallMem, 0);
        chk("mis_lw_rdata", RdataM, 0);
        chk("mis_lw_valid", req_valid, 0);
        tick();
        chk("mis_lw_valid2", req_valid, 0);
        chk("mis_lw_flag2", MisalignM, 1);
        Funct3M = 3'b001; ALUResultM = 32'h303;
        #1;
        chk("mis_lh_flag", MisalignM, 1);
        ALUResultM = 32'h302;
        #1;
        chk("ok_lh_flag", MisalignM, 0);
        chk("ok_lh_stall", StallMem, 1);
        idle_inputs();
        #1;
        chk("mis_clear", MisalignM, 0);
        tick();

        // timeout in REQ: 8 stalled cycles then ERR for one cycle
        MemReadM = 1'b1; Funct3M = 3'b010; ALUResultM = 32'h400; req_ready = 1'b0;
        #1;
        chk("to_idle_stall", StallMem, 1);
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("to_stall", StallMem, 1);
            chk("to_valid", req_valid, 1);
        end
        tick();
        chk("to_buserr", BusErrM, 1);
        chk("to_err_stall", StallMem, 0);
        chk("to_err_valid", req_valid, 0);
        chk("to_err_rdata", RdataM, 0);
        rsp_valid = 1'b1; rsp_rdata = 32'h11111111;
        tick();
        MemReadM = 1'b0;
        #1;
        chk("to_after_buserr", BusErrM, 0);
        chk("to_after_stall", StallMem, 0);
        tick();
        chk("to_late_rsp_valid", req_valid, 0);
        chk("to_late_rsp_rdata", RdataM, 0);
        idle_inputs();
        tick();

        // response with error
        MemReadM = 1'b1; Funct3M = 3'b010; ALUResultM = 32'h500; req_ready = 1'b1;
        tick();
        tick();
        rsp_valid = 1'b1; rsp_err = 1'b1; rsp_rdata = 32'h77777777;
        tick();
        idle_inputs();
        MemReadM = 1'b1;
        #1;
        chk("err_buserr", BusErrM, 1);
        chk("err_rdata", RdataM, 0);
        chk("err_stall", StallMem, 0);
        tick();
        idle_inputs();
        #1;
        chk("err_clear", BusErrM, 0);

        // asynchronous reset while waiting for a response
        MemReadM = 1'b1; Funct3M = 3'b010; ALUResultM = 32'h600; req_ready = 1'b1;
        tick();
        tick();
        chk("ar_wait_stall", StallMem, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_valid", req_valid, 0);
        chk("ar_stall", StallMem, 0);
        rsp_valid = 1'b1; rsp_rdata = 32'h12345678;
        tick();
        chk("ar_held_stall", StallMem, 0);
        chk("ar_held_rdata", RdataM, 0);
        idle_inputs();
        #1 rst_n = 1'b1;
        tick();
        chk("ar_idle_valid", req_valid, 0);
        do_load("ar_lw", 32'h104, 3'b010, 32'hCAFEF00D, 32'h104, 4'b1111, 32'hCAFEF00D);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
